stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr_if.sv | 28 ++
 rtl/stream_mux_rr.sv | 103 ++++++++++
 tb/tb_stream_mux_rr.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// Stream mux bus: N upstream valid/ready/data channels and one downstream
// registered valid/ready/data/chan stream.
//   slave  : mux side (takes up_valid/up_data/down_ready, drives the rest)
//   master : environment side (mirror image)
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SW = $clog2(N);

  logic [N-1:0]       up_valid;
  logic [N*WIDTH-1:0] up_data;
  logic [N-1:0]       up_ready;
  logic               down_valid;
  logic [WIDTH-1:0]   down_data;
  logic [SW-1:0]      down_chan;
  logic               down_ready;

  modport slave (
    input  up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data, down_chan
  );

  modport master (
    output up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data, down_chan
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with a single output register.
// Arbitration is round-robin (search starts after the last accepted channel)
// or fixed priority (lowest index wins), chosen per cycle by fixed_prio.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   fixed_prio  : 0 = round-robin, 1 = fixed priority
//   bus (slave) : up_valid/up_data/up_ready per channel,
//                 down_valid/down_data/down_chan/down_ready output stream

// Per-channel lane: ready gating and AND-OR mux contribution.
module stream_mux_rr_lane #(
  parameter int WIDTH = 8
) (
  input  logic             gnt,
  input  logic             load_en,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_m
);
  assign ready  = gnt & load_en & ~rst;
  assign data_m = gnt ? data : '0;
endmodule

module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fixed_prio,
  stream_mux_rr_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [N-1:0]            grant;
  logic [SW-1:0]           gidx;
  logic                    found;
  logic [SW-1:0]           last;
  logic [SW-1:0]           start;
  logic                    load_en;
  logic [N-1:0][WIDTH-1:0] data_m;
  logic [WIDTH-1:0]        sel_data;

  assign load_en = ~bus.down_valid | bus.down_ready;

  // Rotating search: first asserted valid from start, wrapping at N.
  // Grant never looks at up_data, so ready has no data dependency.
  always_comb begin
    logic [SW:0] idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    if (fixed_prio || last == SW'(N-1)) start = '0;
    else                                start = last + 1'b1;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, start} + (SW+1)'(i);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (!found && bus.up_valid[idx[SW-1:0]]) begin
        found               = 1'b1;
        grant[idx[SW-1:0]]  = 1'b1;
        gidx                = idx[SW-1:0];
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : gen_lane
    stream_mux_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt     (grant[k]),
      .load_en (load_en),
      .rst     (rst),
      .data    (bus.up_data[k*WIDTH +: WIDTH]),
      .ready   (bus.up_ready[k]),
      .data_m  (data_m[k])
    );
  end

  // Grant is one-hot or zero, so OR-ing the masked lanes selects the winner.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) sel_data = sel_data | data_m[k];
  end

  // last resets to N-1 so the first round-robin search begins at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.down_valid <= 1'b0;
      bus.down_data  <= '0;
      bus.down_chan  <= '0;
      last           <= SW'(N-1);
    end else if (load_en) begin
      if (found) begin
        bus.down_valid <= 1'b1;
        bus.down_data  <= sel_data;
        bus.down_chan  <= gidx;
        last           <= gidx;
      end else begin
        bus.down_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst;
  logic fixed_prio;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(8), .N(4)) bus();
  stream_mux_rr #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst(rst), .fixed_prio(fixed_prio), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       fp;
    logic [3:0] uv;
    logic       dr;
    logic [3:0] ur;
    logic       dv;
    logic [1:0] ch;
    logic [7:0] dd;
  } vec_t;

  vec_t tbl[$];

  task automatic set_default_data();
    for (int k = 0; k < 4; k++) bus.up_data[k*8 +: 8] = 8'hA0 + 8'(k);
  endtask

  // Drive at negedge, check ready before the edge, check outputs after it.
  task automatic apply(input string tag, input logic fp, input logic [3:0] uv, input logic dr,
                       input logic [3:0] ur, input logic dv, input logic [1:0] ch, input logic [7:0] dd);
    @(negedge clk);
    fixed_prio     = fp;
    bus.up_valid   = uv;
    bus.down_ready = dr;
    #1;
    chk({tag, "_up_ready"}, bus.up_ready, ur);
    @(posedge clk);
    #1;
    chk({tag, "_down_valid"}, bus.down_valid, dv);
    chk({tag, "_down_chan"}, bus.down_chan, ch);
    chk({tag, "_down_data"}, bus.down_data, dd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [3:0] uv_r;
  logic [3:0] acc;
  logic [5:0] cnt [4];
  int         wait_c [4];
  logic [9:0] sb [$];
  logic [9:0] exp_beat;

  initial begin
    rst = 1'b1; fixed_prio = 1'b0;
    bus.up_valid = 4'b1111; bus.down_ready = 1'b1;
    set_default_data();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_down_valid", bus.down_valid, 1'b0);
    chk("rst_down_chan", bus.down_chan, 2'd0);
    chk("rst_down_data", bus.down_data, 8'h00);
    chk("rst_up_ready", bus.up_ready, 4'b0000);
    @(negedge clk);
    rst = 1'b0; bus.up_valid = 4'b0000;

    // fp, uv, dr, exp up_ready, then expected registered outputs after the edge
    // round-robin sweep 0,1,2,3,0
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
    // fixed priority, channel 3 never wins over 1
    tbl.push_back('{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    tbl.push_back('{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    tbl.push_back('{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    // 5-cycle stall, then next in order after last=1
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2});
    // mode flip takes effect same cycle, last keeps tracking
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1});
    // drain with no upstream: valid drops, data/chan hold
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hA1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 8'hA1});
    // sparse request wrap: after last=1, 3 then 0
    tbl.push_back('{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3});
    tbl.push_back('{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0});

    foreach (tbl[i])
      apply($sformatf("vec%0d", i), tbl[i].fp, tbl[i].uv, tbl[i].dr,
            tbl[i].ur, tbl[i].dv, tbl[i].ch, tbl[i].dd);

    // single beat on channel 2 then idle
    @(negedge clk);
    bus.up_data[2*8 +: 8] = 8'h5C;
    apply("single", 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5C);
    apply("single_end", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h5C);
    set_default_data();

    // reset while a beat is held
    apply("pre_rst", 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 8'hA3);
    @(negedge clk);
    rst = 1'b1; bus.up_valid = 4'b1111; bus.down_ready = 1'b1;
    #1;
    chk("midrst_up_ready", bus.up_ready, 4'b0000);
    @(posedge clk);
    #1;
    chk("midrst_down_valid", bus.down_valid, 1'b0);
    chk("midrst_down_chan", bus.down_chan, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    apply("post_rst", 1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2);

    // random scoreboard: held beat plus accepted beats must match exactly
    @(negedge clk);
    rst = 1'b1; bus.up_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    uv_r = '0;
    for (int k = 0; k < 4; k++) begin cnt[k] = '0; wait_c[k] = 0; end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      fixed_prio = (c >= 5000);
      if (c == 5000) for (int k = 0; k < 4; k++) wait_c[k] = 0;
      for (int k = 0; k < 4; k++)
        if (!uv_r[k] && $urandom_range(0, 1) == 1) begin
          uv_r[k] = 1'b1;
          bus.up_data[k*8 +: 8] = {2'(k), cnt[k]};
        end
      bus.up_valid   = uv_r;
      bus.down_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus.up_ready & uv_r;
      chk("onehot_ready", 32'($onehot0(bus.up_ready)), 1);
      chk("sb_level", sb.size(), 32'(bus.down_valid));
      if (bus.down_valid && bus.down_ready && sb.size() > 0) begin
        exp_beat = sb.pop_front();
        chk("sb_chan", bus.down_chan, exp_beat[9:8]);
        chk("sb_data", bus.down_data, exp_beat[7:0]);
      end
      for (int k = 0; k < 4; k++)
        if (acc[k]) begin
          sb.push_back({2'(k), bus.up_data[k*8 +: 8]});
          cnt[k]++;
          uv_r[k]   = 1'b0;
          wait_c[k] = 0;
        end
      if (acc != 0)
        for (int k = 0; k < 4; k++)
          if (uv_r[k]) begin
            wait_c[k]++;
            if (!fixed_prio) chk($sformatf("rr_wait_ch%0d", k), 32'(wait_c[k] <= 3), 1);
          end
      if (fixed_prio) for (int k = 0; k < 4; k++) wait_c[k] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
